// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 buffered demultiplexer.
package demux_pkg;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNTW_DEF  = 8;
  localparam logic        CH0       = 1'b0;
  localparam logic        CH1       = 1'b1;
endpackage

// File: rtl/demux1t2_8_buf_if.sv
// Bus bundle for demux1t2_8_buf: one input stream, two ready/valid output channels.
interface demux1t2_8_buf_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNTW  = CNTW_DEF
);
  logic [WIDTH-1:0] I;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic             o0_valid;
  logic             o1_valid;
  logic             o0_ready;
  logic             o1_ready;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;

  modport master (
    output I, s, in_valid, o0_ready, o1_ready,
    input  in_ready, o0, o1, o0_valid, o1_valid, cnt0, cnt1
  );

  modport slave (
    input  I, s, in_valid, o0_ready, o1_ready,
    output in_ready, o0, o1, o0_valid, o1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_slot.sv
// One output channel: single-entry data slot with full flag and delivered-word counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             drain_ready,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic [CNTW-1:0]  cnt,
  output logic             space_c
);

  logic deliver_c;

  // Slot can take a word if empty or if its current word leaves this cycle.
  assign deliver_c = full & drain_ready;
  assign space_c   = ~full | drain_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
      cnt  <= '0;
    end else begin
      if (load) begin
        data <= data_in;
        full <= 1'b1;
      end else if (deliver_c) begin
        full <= 1'b0;
      end
      if (deliver_c) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/demux1t2_8_buf.sv
// 1-to-2 demultiplexer with a one-word output buffer per channel.
module demux1t2_8_buf
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNTW  = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  demux1t2_8_buf_if.slave bus
);

  logic space0_c;
  logic space1_c;
  logic in_ready_c;
  logic load0_c;
  logic load1_c;

  // Ready follows only the selected slot; in_valid does not feed back.
  assign in_ready_c   = (bus.s == CH1) ? space1_c : space0_c;
  assign bus.in_ready = in_ready_c;
  assign load0_c      = bus.in_valid & in_ready_c & (bus.s == CH0);
  assign load1_c      = bus.in_valid & in_ready_c & (bus.s == CH1);

  demux_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load0_c),
    .data_in    (bus.I),
    .drain_ready(bus.o0_ready),
    .data       (bus.o0),
    .full       (bus.o0_valid),
    .cnt        (bus.cnt0),
    .space_c    (space0_c)
  );

  demux_slot #(.WIDTH(WIDTH), .CNTW(CNTW)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load1_c),
    .data_in    (bus.I),
    .drain_ready(bus.o1_ready),
    .data       (bus.o1),
    .full       (bus.o1_valid),
    .cnt        (bus.cnt1),
    .space_c    (space1_c)
  );

endmodule

// File: tb/tb_demux1t2_8_buf.sv
// Directed self-checking bench for demux1t2_8_buf.
module tb_demux1t2_8_buf;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  demux1t2_8_buf_if #(.WIDTH(8), .CNTW(8)) bus ();

  demux1t2_8_buf #(.WIDTH(8), .CNTW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sel, input logic [7:0] d);
    bus.in_valid = v;
    bus.s        = sel;
    bus.I        = d;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.s        = 1'b0;
    bus.I        = '0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.I        = '0;
    bus.s        = 1'b0;
    bus.in_valid = 1'b0;
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b0;
    #2;
    check("rst_o0_valid", 32'(bus.o0_valid), 32'd0);
    check("rst_o1_valid", 32'(bus.o1_valid), 32'd0);
    check("rst_o0",       32'(bus.o0),       32'd0);
    check("rst_cnt1",     32'(bus.cnt1),     32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Routing
    bus.o0_ready = 1'b1;
    bus.o1_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h55);
    tick();
    check("route_o0_valid", 32'(bus.o0_valid), 32'd1);
    check("route_o0",       32'(bus.o0),       32'h55);
    drive(1'b1, 1'b1, 8'hAA);
    tick();
    check("route_o1_valid", 32'(bus.o1_valid), 32'd1);
    check("route_o1",       32'(bus.o1),       32'hAA);
    check("route_o0_drain", 32'(bus.o0_valid), 32'd0);
    check("route_cnt0",     32'(bus.cnt0),     32'd1);
    drive(1'b0, 1'b1, 8'hEE);
    tick();
    check("route_cnt1",     32'(bus.cnt1),     32'd1);
    check("idle_o1_valid",  32'(bus.o1_valid), 32'd0);
    check("idle_cnt0",      32'(bus.cnt0),     32'd1);

    // Backpressure on channel 0
    do_reset();
    bus.o0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11);
    check("bp_ready_first", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_o0_first", 32'(bus.o0), 32'h11);
    drive(1'b1, 1'b0, 8'h22);
    check("bp_ready_blocked", 32'(bus.in_ready), 32'd0);
    tick();
    check("bp_o0_hold",       32'(bus.o0),       32'h11);
    check("bp_valid_hold",    32'(bus.o0_valid), 32'd1);
    check("bp_still_blocked", 32'(bus.in_ready), 32'd0);
    bus.o0_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_o0_second", 32'(bus.o0),       32'h22);
    check("bp_valid_b2b", 32'(bus.o0_valid), 32'd1);
    check("bp_cnt0_one",  32'(bus.cnt0),     32'd1);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("bp_cnt0_two",  32'(bus.cnt0),     32'd2);
    check("bp_empty",     32'(bus.o0_valid), 32'd0);

    // Streaming on channel 1
    do_reset();
    bus.o1_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      check("stream_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("stream_o1",    32'(bus.o1),       32'(i));
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("stream_cnt1",     32'(bus.cnt1),     32'd16);
    check("stream_no_leak",  32'(bus.o0_valid), 32'd0);
    check("stream_cnt0",     32'(bus.cnt0),     32'd0);

    // Counter wrap on channel 0
    do_reset();
    bus.o0_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("wrap_cnt0_zero", 32'(bus.cnt0), 32'd0);
    drive(1'b1, 1'b0, 8'h5A);
    tick();
    check("wrap_o0", 32'(bus.o0), 32'h5A);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("wrap_cnt0_one", 32'(bus.cnt0), 32'd1);

    // Cross traffic: channel 1 stalled, channel 0 still accepts
    bus.o0_ready = 1'b0;
    bus.o1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h77);
    tick();
    check("cross_o1", 32'(bus.o1), 32'h77);
    drive(1'b1, 1'b0, 8'h33);
    check("cross_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("cross_o0",       32'(bus.o0),       32'h33);
    check("cross_o0_valid", 32'(bus.o0_valid), 32'd1);
    check("cross_o1_hold",  32'(bus.o1),       32'h77);
    drive(1'b0, 1'b1, 8'h99);
    check("cross_ready_s1", 32'(bus.in_ready), 32'd0);

    // Asynchronous reset with both slots full
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o0_valid", 32'(bus.o0_valid), 32'd0);
    check("arst_o1_valid", 32'(bus.o1_valid), 32'd0);
    check("arst_cnt0",     32'(bus.cnt0),     32'd0);
    check("arst_o1",       32'(bus.o1),       32'd0);
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.o0_ready = 1'b1;
    bus.o1_ready = 1'b1;
    tick();
    check("arst_no_stale0", 32'(bus.o0_valid), 32'd0);
    check("arst_no_stale1", 32'(bus.o1_valid), 32'd0);
    check("arst_cnt1",      32'(bus.cnt1),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux1t2_8_buf.md
DEMUX1T2_8_BUF -- requirements
Module: demux1t2_8_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of input and both outputs.
REQ-002 SHALL have parameter CNTW, default 8, width of each delivered-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I  input  WIDTH  input data word.
REQ-006 SHALL have port s  input  1  destination select: 0 -> channel 0, 1 -> channel 1.
REQ-007 SHALL have port in_valid  input  1  I/s valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts I this cycle.
REQ-009 SHALL have port o0 / o1  output  WIDTH  channel 0 / 1 data.
REQ-010 SHALL have port o0_valid / o1_valid  output  1  channel data valid.
REQ-011 SHALL have port o0_ready / o1_ready  input  1  channel consumer accepts.
REQ-012 SHALL have port cnt0 / cnt1  output  CNTW  words delivered on channel 0 / 1.

Function
REQ-013 SHALL hold one output slot per channel: data register plus full flag; oN_valid = full flag N, oN = data register N.
REQ-014 SHALL drive in_ready combinationally = (slot[s] empty) OR (oS_valid AND oS_ready), where S = s; no dependency on in_valid.
REQ-015 SHALL accept a word when in_valid AND in_ready; slot[s] loads I at that edge, oS_valid rises next cycle (latency 1).
REQ-016 SHALL deliver on channel N when oN_valid AND oN_ready; slot N clears at that edge unless reloaded in the same cycle.
REQ-017 SHALL, on simultaneous drain and load of the same slot, load the new word with valid staying 1 (back-to-back, one word per cycle throughput).
REQ-018 SHALL allow load of one channel and drain of the other in the same cycle, independently.
REQ-019 SHALL keep oN and oN_valid stable while oN_valid=1 and oN_ready=0.
REQ-020 SHALL never route a word to the unselected channel; s is sampled only on accept.
REQ-021 SHALL increment cntN by 1 on every channel-N delivery; wrap 2^CNTW-1 -> 0 without saturation or flag.
REQ-022 SHALL ignore I and s when in_valid=0; no state change on input side.

Reset
REQ-023 SHALL, while rst_n=0, force o0_valid=o1_valid=0, o0=o1=0, cnt0=cnt1=0, independent of clk.
REQ-024 SHALL discard any buffered word on reset mid-operation; no delivery of pre-reset data after release.
REQ-025 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; in_ready=1 in that cycle (both slots empty).

Structure
REQ-026 SHALL place WIDTH/CNTW defaults and channel index constants (CH0=0, CH1=1) in shared package demux_pkg.
REQ-027 SHALL implement each channel as one instance of sub-module demux_slot (data reg, full flag, counter, load/drain logic), instantiated twice.
REQ-028 SHALL keep top level limited to select decode, in_ready mux and slot wiring.

Verification
REQ-029 SHALL cover reset: assert rst_n=0 asynchronously mid-cycle with both slots full -> o0_valid=o1_valid=0, cnt0=cnt1=0 immediately.
REQ-030 SHALL cover routing: I=8'h55,s=0 then I=8'hAA,s=1, both readies 1 -> o0=8'h55 next cycle, o1=8'hAA cycle after; cnt0=cnt1=1.
REQ-031 SHALL cover backpressure: o0_ready=0, send 8'h11 then 8'h22 to s=0 -> o0 holds 8'h11, in_ready=0 for second word until o0_ready=1; then 8'h22 accepted same cycle.
REQ-032 SHALL cover streaming: 16 words 8'h00..8'h0F to s=1, o1_ready=1 throughout -> one word per cycle, order preserved, cnt1=16.
REQ-033 SHALL cover wrap: 256 deliveries on channel 0 -> cnt0 returns to 0; 257th -> cnt0=1.
REQ-034 SHALL cover cross-traffic: o1 stalled full, send 8'h33 to s=0 -> accepted (in_ready=1), o0=8'h33; o1 data unchanged.
